// File: rtl/seq_divider_if.sv
// Operand/result bundle between the issue logic and the sequential divider.
// The master drives the operands and start. The slave returns the status pulses and hi/lo.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider producing lo=quotient and hi=remainder. done pulses WIDTH+2 cycles after start.
// A start request while busy is dropped. A zero divisor returns a div_zero pulse and leaves hi/lo untouched.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_count;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_zero_req;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_zero_req = (r_state == S_IDLE) && bus.start && (bus.divisor == '0);
  assign w_accept   = (r_state == S_IDLE) && bus.start && (bus.divisor != '0);
  assign w_dvd_mag  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_dsr_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  // The partial remainder stays below |divisor|, which is at most 2^(WIDTH-1).
  // The shifted remainder therefore needs one extra bit, and the difference fits back in WIDTH bits.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_diff  = WIDTH'(w_shift - {1'b0, r_dsr});

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        w_busy = 1'b1;
        if (r_count == CW'(WIDTH - 1)) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_quot     <= '0;
      r_rem      <= '0;
      r_dsr      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_count    <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_div_zero <= w_zero_req;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_quot   <= w_dvd_mag;
          r_dsr    <= w_dsr_mag;
          r_rem    <= '0;
          r_count  <= '0;
          r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          r_sign_r <= bus.dividend[WIDTH-1];
        end
        S_CALC: begin
          r_rem   <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quot  <= {r_quot[WIDTH-2:0], w_ge};
          r_count <= r_count + 1'b1;
        end
        // The most negative dividend over -1 wraps back to itself here.
        S_FIX: begin
          r_lo <= r_sign_q ? -r_quot : r_quot;
          r_hi <= r_sign_r ? -r_rem  : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule
